// File: rtl/dmx_tx_pkg.sv
// Shared definitions for the DMX512 transmit path: FSM states, frame geometry,
// and the slot-count clamp applied when a frame is launched.
package dmx_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BREAK,
        S_MAB,
        S_SLOT,
        S_MTBS,
        S_MBB
    } dmx_state_e;

    // Start code plus 512 data slots
    localparam int DMX_MAX_SLOTS = 513;
    // start + 8 data + 2 stop
    localparam int DMX_SLOT_BITS = 11;

    // A zero request still sends the start code; anything past the buffer is capped
    function automatic logic [9:0] clamp_slot_count(input logic [9:0] n);
        if (n == 10'd0)
            return 10'd1;
        if (n > 10'(DMX_MAX_SLOTS))
            return 10'(DMX_MAX_SLOTS);
        return n;
    endfunction

endpackage

// File: rtl/dmx_tx_uart_tx_8n2.sv
// 8N2 byte serializer. o_Serial is a direct decode of the shift register, so
// the first start-bit cycle lines up with the cycle after i_Load. o_Done marks
// the final stop-bit cycle; loading on that cycle chains bytes with no gap.
module uart_tx_8n2
    import dmx_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 64
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Load,
    input  logic [7:0] i_Byte,
    output logic       o_Serial,
    output logic       o_Done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DMX_SLOT_BITS - 1);

    logic                     busy;
    logic [TW-1:0]            tick;
    logic [3:0]               bit_idx;
    logic [DMX_SLOT_BITS-1:0] shreg;

    assign o_Serial = busy ? shreg[0] : 1'b1;
    assign o_Done   = busy && (tick == TICK_LAST) && (bit_idx == BIT_LAST);

    // Shift one frame bit out every CLKS_PER_BIT cycles, LSB first, mark fill
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            busy    <= 1'b0;
            tick    <= '0;
            bit_idx <= '0;
            shreg   <= '1;
        end else if (i_Load) begin
            busy    <= 1'b1;
            tick    <= '0;
            bit_idx <= '0;
            shreg   <= {2'b11, i_Byte, 1'b0};
        end else if (busy) begin
            if (tick == TICK_LAST) begin
                tick  <= '0;
                shreg <= {1'b1, shreg[DMX_SLOT_BITS-1:1]};
                if (bit_idx == BIT_LAST)
                    busy <= 1'b0;
                else
                    bit_idx <= bit_idx + 4'd1;
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

endmodule

// File: rtl/dmx_tx.sv
// DMX512 frame transmitter: slot buffer, BREAK/MAB/MTBS/MBB timing and slot
// sequencing around the 8N2 serializer. The buffer is read every cycle at the
// address of the slot that will be loaded next, so the value that gets sent is
// whatever the RAM held one cycle before the serializer's load (read-first).
module dmx_tx
    import dmx_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 64,
    parameter int BREAK_BITS   = 24,
    parameter int MAB_BITS     = 3,
    parameter int MTBS_BITS    = 0,
    parameter int MBB_BITS     = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_WrEn,
    input  logic [9:0] i_WrAddr,
    input  logic [7:0] i_WrData,
    input  logic [9:0] i_SlotCount,
    input  logic       i_Start,
    input  logic       i_Continuous,
    output logic       o_Tx,
    output logic       o_TxEn,
    output logic       o_Busy,
    output logic       o_FrameDone
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    BRK_LAST  = 8'(BREAK_BITS - 1);
    localparam logic [7:0]    MAB_LAST  = 8'(MAB_BITS - 1);
    localparam logic [7:0]    MTBS_LAST = 8'(MTBS_BITS - 1);
    localparam logic [7:0]    MBB_LAST  = 8'(MBB_BITS - 1);

    dmx_state_e    state;
    logic [TW-1:0] tick;
    logic [7:0]    bit_cnt;
    logic [9:0]    slot_idx;
    logic [9:0]    slot_last;
    logic          tx_q;

    logic [7:0]    mem [0:DMX_MAX_SLOTS-1];
    logic [7:0]    rd_data;
    logic [9:0]    rd_addr;

    logic          ser;
    logic          ser_done;
    logic          load;
    logic          tick_last;

    assign tick_last = (tick == TICK_LAST);

    // While a slot is on the wire, prefetch the one after it
    always_comb begin
        rd_addr = slot_idx;
        if (state == S_SLOT)
            rd_addr = slot_idx + 10'd1;
    end

    // Serializer load points: end of MAB, end of MTBS, or back-to-back slots
    always_comb begin
        load = 1'b0;
        case (state)
            S_MAB:   load = tick_last && (bit_cnt == MAB_LAST);
            S_MTBS:  load = tick_last && (bit_cnt == MTBS_LAST);
            S_SLOT:  load = ser_done && (slot_idx != slot_last) && (MTBS_BITS == 0);
            default: load = 1'b0;
        endcase
    end

    // Slot buffer: host writes any time, synchronous read-first port
    always_ff @(posedge i_Clock) begin
        if (i_WrEn && (i_WrAddr < 10'(DMX_MAX_SLOTS)))
            mem[i_WrAddr] <= i_WrData;
        if (rd_addr < 10'(DMX_MAX_SLOTS))
            rd_data <= mem[rd_addr];
    end

    uart_tx_8n2 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Load   (load),
        .i_Byte   (rd_data),
        .o_Serial (ser),
        .o_Done   (ser_done)
    );

    assign o_Tx = (state == S_SLOT) ? ser : tx_q;

    // Frame sequencer; timed states share one tick/bit counter pair
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            tick        <= '0;
            bit_cnt     <= '0;
            slot_idx    <= '0;
            slot_last   <= '0;
            tx_q        <= 1'b1;
            o_TxEn      <= 1'b0;
            o_Busy      <= 1'b0;
            o_FrameDone <= 1'b0;
        end else begin
            o_FrameDone <= 1'b0;
            if (state inside {S_BREAK, S_MAB, S_MTBS, S_MBB}) begin
                if (tick_last) begin
                    tick    <= '0;
                    bit_cnt <= bit_cnt + 8'd1;
                end else begin
                    tick <= tick + TW'(1);
                end
            end
            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        state     <= S_BREAK;
                        tick      <= '0;
                        bit_cnt   <= '0;
                        slot_last <= clamp_slot_count(i_SlotCount) - 10'd1;
                        tx_q      <= 1'b0;
                        o_TxEn    <= 1'b1;
                        o_Busy    <= 1'b1;
                    end
                end
                S_BREAK: begin
                    if (tick_last && (bit_cnt == BRK_LAST)) begin
                        state    <= S_MAB;
                        bit_cnt  <= '0;
                        slot_idx <= '0;
                        tx_q     <= 1'b1;
                    end
                end
                S_MAB: begin
                    if (tick_last && (bit_cnt == MAB_LAST)) begin
                        state   <= S_SLOT;
                        bit_cnt <= '0;
                    end
                end
                S_SLOT: begin
                    if (ser_done) begin
                        if (slot_idx == slot_last) begin
                            state       <= S_MBB;
                            o_FrameDone <= 1'b1;
                        end else begin
                            slot_idx <= slot_idx + 10'd1;
                            if (MTBS_BITS != 0)
                                state <= S_MTBS;
                        end
                    end
                end
                S_MTBS: begin
                    if (tick_last && (bit_cnt == MTBS_LAST)) begin
                        state   <= S_SLOT;
                        bit_cnt <= '0;
                    end
                end
                S_MBB: begin
                    if (tick_last && (bit_cnt == MBB_LAST)) begin
                        bit_cnt <= '0;
                        if (i_Continuous) begin
                            state     <= S_BREAK;
                            slot_last <= clamp_slot_count(i_SlotCount) - 10'd1;
                            tx_q      <= 1'b0;
                        end else begin
                            state  <= S_IDLE;
                            o_TxEn <= 1'b0;
                            o_Busy <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmx_tx.sv
// Bench for dmx_tx: captures the line while the driver is enabled and compares
// it against a frame built from the DMX timing rules and a shadow of the buffer.
module tb_dmx_tx;

    localparam int CPB     = 4;
    localparam int BRK     = 24;
    localparam int MAB     = 3;
    localparam int MTBS    = 0;
    localparam int MBB     = 4;
    localparam int BRK_C   = BRK * CPB;
    localparam int MAB_C   = MAB * CPB;
    localparam int MTBS_C  = MTBS * CPB;
    localparam int MBB_C   = MBB * CPB;
    localparam int SLOT_C  = 11 * CPB;
    localparam int GUARD   = 60000;

    logic       clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_WrEn = 1'b0;
    logic [9:0] i_WrAddr = '0;
    logic [7:0] i_WrData = '0;
    logic [9:0] i_SlotCount = '0;
    logic       i_Start = 1'b0;
    logic       i_Continuous = 1'b0;
    logic       o_Tx, o_TxEn, o_Busy, o_FrameDone;

    dmx_tx #(
        .CLKS_PER_BIT (CPB),
        .BREAK_BITS   (BRK),
        .MAB_BITS     (MAB),
        .MTBS_BITS    (MTBS),
        .MBB_BITS     (MBB)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (i_Reset),
        .i_WrEn       (i_WrEn),
        .i_WrAddr     (i_WrAddr),
        .i_WrData     (i_WrData),
        .i_SlotCount  (i_SlotCount),
        .i_Start      (i_Start),
        .i_Continuous (i_Continuous),
        .o_Tx         (o_Tx),
        .o_TxEn       (o_TxEn),
        .o_Busy       (o_Busy),
        .o_FrameDone  (o_FrameDone)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem_m [0:512];
    bit         cap_q [$];
    bit         exp_q [$];
    int         done_q [$];
    int         busy_bad;
    int         first_idx;
    int         wr_at = -1, start_at = -1, drop_at = -1;
    logic [9:0] wr_addr_p;
    logic [7:0] wr_data_p;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        @(negedge clk);
        i_WrEn = 1'b1;
        i_WrAddr = 10'(addr);
        i_WrData = data;
        if (addr < 513)
            mem_m[addr] = data;
        @(negedge clk);
        i_WrEn = 1'b0;
    endtask

    // Launch a frame and record the line for as long as the driver is enabled
    task automatic run(input int cnt, input bit cont);
        int  idx = 0;
        int  guard = 0;
        bit  started = 0;
        cap_q.delete();
        done_q.delete();
        busy_bad = 0;
        first_idx = -1;
        @(negedge clk);
        i_SlotCount = 10'(cnt);
        i_Start = 1'b1;
        i_Continuous = cont;
        while (guard < GUARD) begin
            @(negedge clk);
            guard++;
            i_Start = 1'b0;
            i_WrEn = 1'b0;
            if (!started && o_TxEn) begin
                started = 1;
                first_idx = guard;
            end
            if (started) begin
                if (!o_TxEn)
                    break;
                cap_q.push_back(o_Tx);
                if (o_FrameDone)
                    done_q.push_back(idx);
                if (!o_Busy)
                    busy_bad++;
                if (idx == drop_at)
                    i_Continuous = 1'b0;
                if (idx == start_at)
                    i_Start = 1'b1;
                if (idx == wr_at) begin
                    i_WrEn = 1'b1;
                    i_WrAddr = wr_addr_p;
                    i_WrData = wr_data_p;
                end
                idx++;
            end
        end
        i_WrEn = 1'b0;
        i_Continuous = 1'b0;
        chk("frame_ended", 32'(guard < GUARD), 1);
        chk("start_latency", first_idx, 1);
        chk("busy_while_en", busy_bad, 0);
        chk("idle_tx", 32'(o_Tx), 1);
        chk("idle_busy", 32'(o_Busy), 0);
    endtask

    // Expected line: break, MAB, each slot as start/D0..D7/stop/stop, MTBS, MBB
    task automatic verify(input int cnt, input int frames);
        int n, flen, diffs, pos, base, lim;
        logic [7:0] b;
        bit v;
        n = (cnt == 0) ? 1 : ((cnt > 513) ? 513 : cnt);
        flen = BRK_C + MAB_C + n * SLOT_C + (n - 1) * MTBS_C + MBB_C;
        exp_q.delete();
        for (int f = 0; f < frames; f++) begin
            repeat (BRK_C) exp_q.push_back(1'b0);
            repeat (MAB_C) exp_q.push_back(1'b1);
            for (int s = 0; s < n; s++) begin
                for (int k = 0; k < 11; k++) begin
                    v = (k == 0) ? 1'b0 : ((k <= 8) ? mem_m[s][k-1] : 1'b1);
                    repeat (CPB) exp_q.push_back(v);
                end
                if (s < n - 1)
                    repeat (MTBS_C) exp_q.push_back(1'b1);
            end
            repeat (MBB_C) exp_q.push_back(1'b1);
        end
        chk("frame_len", cap_q.size(), exp_q.size());
        lim = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        diffs = 0;
        for (int i = 0; i < lim; i++)
            if (cap_q[i] != exp_q[i])
                diffs++;
        chk("wave_diffs", diffs, 0);
        chk("done_pulses", done_q.size(), frames);
        for (int f = 0; f < frames && f < done_q.size(); f++)
            chk($sformatf("done_at_f%0d", f), done_q[f], f * flen + flen - MBB_C);
        for (int f = 0; f < frames; f++) begin
            for (int s = 0; s < n; s++) begin
                base = f * flen + BRK_C + MAB_C + s * (SLOT_C + MTBS_C);
                b = '0;
                for (int k = 0; k < 8; k++) begin
                    pos = base + (1 + k) * CPB + CPB / 2;
                    b[k] = (pos < cap_q.size()) ? cap_q[pos] : 1'bx;
                end
                chk($sformatf("f%0d_slot%0d", f, s), b, mem_m[s]);
            end
        end
    endtask

    initial begin
        int bad, n2, s1;

        // Reset and idle line
        repeat (3) @(negedge clk);
        i_Reset = 1'b0;
        @(negedge clk);
        chk("rst_tx", 32'(o_Tx), 1);
        chk("rst_txen", 32'(o_TxEn), 0);
        chk("rst_busy", 32'(o_Busy), 0);
        chk("rst_done", 32'(o_FrameDone), 0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_Tx !== 1'b1 || o_TxEn !== 1'b0 || o_Busy !== 1'b0)
                bad++;
        end
        chk("idle_100", bad, 0);

        // Directed 3-slot frame
        wr(0, 8'h00);
        wr(1, 8'hA5);
        wr(2, 8'h3C);
        run(3, 0);
        verify(3, 1);

        // Random buffer contents; out-of-range writes must not land anywhere
        for (int a = 0; a < 513; a++)
            wr(a, 8'($urandom));
        wr(513, 8'h5A);
        wr(700, 8'hC3);
        for (int t = 0; t < 4; t++) begin
            int c;
            c = $urandom_range(1, 12);
            run(c, 0);
            verify(c, 1);
        end

        // Clamp boundaries
        run(0, 0);
        verify(0, 1);
        run(600, 0);
        verify(600, 1);

        // Continuous mode, dropped during slot 1 of the second frame
        n2 = BRK_C + MAB_C + 2 * SLOT_C + MTBS_C + MBB_C;
        drop_at = n2 + BRK_C + MAB_C + SLOT_C + SLOT_C / 2;
        run(2, 1);
        drop_at = -1;
        verify(2, 2);

        // A start request mid-frame is dropped, not queued
        start_at = 50;
        run(2, 0);
        start_at = -1;
        verify(2, 1);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_TxEn !== 1'b0)
                bad++;
        end
        chk("no_queued_start", bad, 0);

        // Overwrite slot 1 while it is in its second stop bit
        s1 = BRK_C + MAB_C + SLOT_C;
        wr_at = s1 + 10 * CPB + 1;
        wr_addr_p = 10'd1;
        wr_data_p = 8'hFF;
        run(3, 0);
        wr_at = -1;
        verify(3, 1);
        mem_m[1] = 8'hFF;
        run(3, 0);
        verify(3, 1);

        // Reset during slot 1, then a clean frame
        @(negedge clk);
        i_SlotCount = 10'd3;
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        repeat (BRK_C + MAB_C + SLOT_C + 5) @(negedge clk);
        chk("pre_rst_txen", 32'(o_TxEn), 1);
        i_Reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx", 32'(o_Tx), 1);
        chk("midrst_txen", 32'(o_TxEn), 0);
        chk("midrst_busy", 32'(o_Busy), 0);
        i_Reset = 1'b0;
        repeat (3) @(negedge clk);
        run(3, 0);
        verify(3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmx_tx.md
Name: dmx_tx

Overview:
- DMX512 transmitter, the output-side counterpart of the existing uart_rx/dmx_rx receive chain.
- Holds a 513-byte slot buffer (slot 0 = start code), written by the host-side logic.
- On request, emits a full frame on the RS-485 driver: BREAK, MAB, then N slots of 8N2 at 250 kbaud, then MBB. Drives the transceiver enable.
- Optional continuous mode restarts frames back to back.

Parameters:
- CLKS_PER_BIT, 64: clocks per bit (16 MHz clock gives 250 kbaud).
- BREAK_BITS, 24: break length in bit times (96 us); must be >= 22.
- MAB_BITS, 3: mark-after-break length in bit times (12 us).
- MTBS_BITS, 0: extra mark time between slots, in bit times.
- MBB_BITS, 4: mark-before-break idle after the last slot, in bit times.

Ports:
- i_Clock  in  1  system clock, same domain as uart_rx.
- i_Reset  in  1  synchronous, active-high reset.
- i_WrEn  in  1  buffer write strobe.
- i_WrAddr  in  10  slot address, 0..512; writes to addresses >512 are ignored.
- i_WrData  in  8  slot data.
- i_SlotCount  in  10  slots per frame including the start code; sampled at frame start.
- i_Start  in  1  request one frame; level-sensitive, honoured only in IDLE.
- i_Continuous  in  1  auto-restart after MBB while high.
- o_Tx  out  1  serial line; mark = 1.
- o_TxEn  out  1  RS-485 driver enable.
- o_Busy  out  1  high whenever state != IDLE.
- o_FrameDone  out  1  one-cycle pulse at the end of the last slot's second stop bit.

Behaviour:
- Reset
  - All outputs: o_Tx=1, o_TxEn=0, o_Busy=0, o_FrameDone=0; state=IDLE; all counters 0.
  - Buffer contents are not cleared.
  - Reset asserted mid-frame takes effect on the next edge: the line returns to mark and o_TxEn drops immediately. A truncated slot is acceptable.
- Slot count latch
  - Occurs at IDLE->BREAK.
  - Value 0 is clamped to 1; values >513 are clamped to 513.
- FSM, one bit-tick counter 0..CLKS_PER_BIT-1 plus a bit counter:
  - IDLE: o_Tx=1, o_TxEn=0. If i_Start=1, go to BREAK next cycle. o_TxEn=1 and o_Tx=0 in the first BREAK cycle, so latency is 1 clock.
  - BREAK: o_Tx=0 for exactly BREAK_BITS*CLKS_PER_BIT cycles, then MAB.
  - MAB: o_Tx=1 for MAB_BITS*CLKS_PER_BIT cycles, then SLOT with slot index 0.
  - SLOT: delegates to the sub-module. Bit order is start(0), D0..D7 LSB first, stop, stop, for 11*CLKS_PER_BIT cycles.
    - On the serializer's done signal: if index == latched count-1, go to MBB and pulse o_FrameDone.
    - Otherwise increment the index and go to MTBS, or directly to SLOT if MTBS_BITS=0.
  - MTBS: o_Tx=1 for MTBS_BITS*CLKS_PER_BIT cycles, then SLOT.
  - MBB: o_Tx=1, o_TxEn=1 for MBB_BITS*CLKS_PER_BIT cycles.
    - Then BREAK if i_Continuous=1, re-latching i_SlotCount.
    - Otherwise IDLE, with o_TxEn=0 on the IDLE cycle.
- Gap-free slots
  - The buffer is 513x8 with synchronous 1-cycle read (maps to SB_RAM40).
  - The next slot's read address is issued during the current slot's second stop bit, so consecutive slots are contiguous with zero gap cycles.
- Buffer write collisions
  - Writes are accepted in every state.
  - A write and a read to the same address in the same cycle returns the old data (read-first). The new value appears in the next frame.
- Start handling
  - i_Start while Busy is ignored; it does not queue.
  - i_Start held high in IDLE starts exactly one frame per IDLE entry.
- i_Continuous deasserted mid-frame finishes the current frame, then goes to IDLE.

Decomposition:
- Shared header dmx_defs.vh holds:
  - state encodings: S_IDLE, S_BREAK, S_MAB, S_SLOT, S_MTBS, S_MBB;
  - DMX_MAX_SLOTS=513;
  - DMX_SLOT_BITS=11.
- Sub-module uart_tx_8n2 (parameter CLKS_PER_BIT).
  - Ports: i_Clock, i_Reset, i_Load, i_Byte, o_Serial, o_Done.
  - o_Done is a one-cycle pulse on the final stop-bit cycle.
  - i_Load on the same cycle as o_Done starts the next byte without an idle bit.
- dmx_tx owns the RAM, the FSM and the break/mark timers.

Test Plan:
- Reset, then check idle → o_Tx=1, o_TxEn=0, o_Busy=0 for 100 cycles.
- Write slot0=0x00, 1=0xA5, 2=0x3C; SlotCount=3; pulse i_Start → line low for exactly 1536 cycles, high for 192, then 3 slots of 704 cycles each (decode 0x00, 0xA5, 0x3C LSB first). o_FrameDone pulses 3840 cycles after BREAK entry; o_TxEn drops 256 cycles later.
- SlotCount=0 → 1 slot sent. SlotCount=600 → 513 slots sent, addresses 0..512, no gap cycles between slots.
- i_Continuous=1 with SlotCount=2 → back-to-back frames with a 256-cycle MBB then a 1536-cycle break. Deassert mid-slot 1 → that frame completes, then IDLE.
- Write 0xFF to slot 1 during slot 1's second stop bit → current frame sends the old value; the next frame sends 0xFF.
- Assert i_Reset mid-slot 1 → next cycle o_Tx=1, o_TxEn=0, o_Busy=0; a following i_Start gives a clean full frame.
